// File: rtl/cache_pmem_arbiter.sv
// Shares one pmem port between I-cache fills and D-cache fills/writebacks; `ARB_RR_EN selects round-robin I/D.
// Latency: strobe from the cycle after the grant edge; resp is combinational on pmem_resp for the winner only.
// Backpressure: requests are levels held until resp; losers wait, and one IDLE cycle separates transactions.
module cache_pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              d_req;
  logic              d_wins;
  logic              grant;

  assign d_req = d_write | d_read;

`ifdef ARB_RR_EN
  // last_grant_q: 0 = I-cache, 1 = D-cache
  logic last_grant_q;

  assign d_wins = d_req & (~i_read | ~last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else if (grant) begin
      last_grant_q <= (state_d != I_RD);
    end
  end
`else
  assign d_wins = d_req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_wins) begin
          // writeback drains the victim line before the fill that replaces it
          state_d = d_write ? D_WR : D_RD;
        end else if (i_read) begin
          state_d = I_RD;
        end
      end
      I_RD, D_RD, D_WR: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address/data are frozen at the grant so the requester may change its inputs freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      addr_q <= (state_d == I_RD) ? i_addr : d_addr;
      if (state_d == D_WR) begin
        wdata_q <= d_wdata;
      end
    end
  end

  assign pmem_read  = (state_q == I_RD) || (state_q == D_RD);
  assign pmem_write = (state_q == D_WR);
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;

  assign i_resp  = (state_q == I_RD) & pmem_resp;
  assign d_resp  = ((state_q == D_RD) || (state_q == D_WR)) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Directed bench for cache_pmem_arbiter: grant order, latching, resp routing, reset abort.
module tb_cache_pmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_pass   = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int excl_err   = 0;

  cache_pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+2, so negedge sees settled values.
  always @(negedge clk) begin
    if (i_resp) i_resp_cnt++;
    if (d_resp) d_resp_cnt++;
    if (pmem_read && pmem_write) excl_err++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Waits for a strobe, checks it, pulses pmem_resp after two cycles, checks routing and the IDLE gap.
  task automatic do_txn(input string tag, input bit exp_wr, input bit exp_i,
                        input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                        input logic [255:0] rdata, input bit drop);
    bit seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      #1;
      seen = pmem_read | pmem_write;
    end
    check({tag, "_grant"}, 256'(seen), 256'(1));
    if (!seen) return;
    check({tag, "_rd"}, 256'(pmem_read), 256'(!exp_wr));
    check({tag, "_wr"}, 256'(pmem_write), 256'(exp_wr));
    check({tag, "_addr"}, 256'(pmem_addr), 256'(exp_addr));
    if (exp_wr) check({tag, "_wdata"}, pmem_wdata, exp_wdata);
    step();
    step();
    pmem_resp  = 1'b1;
    pmem_rdata = rdata;
    #1;
    check({tag, "_iresp"}, 256'(i_resp), 256'(exp_i));
    check({tag, "_dresp"}, 256'(d_resp), 256'(!exp_i));
    check({tag, "_rdata"}, exp_i ? i_rdata : d_rdata, rdata);
    step();
    pmem_resp = 1'b0;
    if (drop) begin
      if (exp_i) i_read = 1'b0;
      else if (exp_wr) d_write = 1'b0;
      else d_read = 1'b0;
    end
    #1;
    check({tag, "_gap"}, 256'({pmem_read, pmem_write}), 256'(0));
  endtask

  initial begin
    int i0;
    int d0;
    bit exp_i;
    rst_n = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    #3;
    check("rst_rd", 256'(pmem_read), 256'(0));
    check("rst_wr", 256'(pmem_write), 256'(0));
    check("rst_addr", 256'(pmem_addr), 256'(0));
    check("rst_wdata", pmem_wdata, 256'(0));
    check("rst_resp", 256'({i_resp, d_resp}), 256'(0));
    step();
    rst_n = 1'b1;

    // 1 + 4: lone I fill, address changed mid-transaction
    i0 = i_resp_cnt; d0 = d_resp_cnt;
    step();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    #1;
    check("t1_no_comb", 256'(pmem_read), 256'(0));
    step();
    #1;
    check("t1_rd", 256'(pmem_read), 256'(1));
    check("t1_addr", 256'(pmem_addr), 256'(32'h1000));
    i_addr = 32'h0000_3000;
    for (int k = 0; k < 4; k++) begin
      step();
      #1;
      check("t4_addr_held", 256'(pmem_addr), 256'(32'h1000));
      check("t1_rd_held", 256'(pmem_read), 256'(1));
    end
    pmem_resp = 1'b1; pmem_rdata = {32{8'hA5}};
    #1;
    check("t1_iresp", 256'(i_resp), 256'(1));
    check("t1_irdata", i_rdata, {32{8'hA5}});
    step();
    pmem_resp = 1'b0; i_read = 1'b0;
    #1;
    check("t1_idle", 256'(pmem_read), 256'(0));
    check("t1_icnt", 256'(i_resp_cnt - i0), 256'(1));
    check("t1_dcnt", 256'(d_resp_cnt - d0), 256'(0));

    // 2: I and D fills together, D first under both arbitration modes
    i_read = 1'b1; i_addr = 32'h1000; d_read = 1'b1; d_addr = 32'h4000;
    do_txn("t2_d", 1'b0, 1'b0, 32'h4000, '0, {8{32'hD00D_0001}}, 1'b1);
    do_txn("t2_i", 1'b0, 1'b1, 32'h1000, '0, {8{32'h1111_0002}}, 1'b1);

    // 3: writeback precedes fill
    d_write = 1'b1; d_read = 1'b1; d_addr = 32'h2000; d_wdata = {16{16'h1234}};
    do_txn("t3_wb", 1'b1, 1'b0, 32'h2000, {16{16'h1234}}, '0, 1'b1);
    d_wdata = '0;
    do_txn("t3_fill", 1'b0, 1'b0, 32'h2000, '0, {8{32'hCAFE_0003}}, 1'b1);

    // 5: reset during D_RD abandons the transaction
    d_read = 1'b1; d_addr = 32'h5000;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        step();
        #1;
        seen = pmem_read;
      end
      check("t5_grant", 256'(seen), 256'(1));
    end
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rd_drop", 256'(pmem_read), 256'(0));
    check("t5_addr_clr", 256'(pmem_addr), 256'(0));
    step();
    rst_n = 1'b1; d_read = 1'b0; pmem_resp = 1'b1;
    #1;
    check("t5_no_resp", 256'({i_resp, d_resp}), 256'(0));
    step();
    pmem_resp = 1'b0;
    #1;
    check("t5_idle", 256'({pmem_read, pmem_write}), 256'(0));

    // 6: both fills held continuously; RR alternates D,I,... fixed priority keeps D
    i_read = 1'b1; i_addr = 32'h6000; d_read = 1'b1; d_addr = 32'h7000;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      exp_i = (k % 2) == 1;
`else
      exp_i = 1'b0;
`endif
      do_txn($sformatf("t6_%0d", k), 1'b0, exp_i, exp_i ? 32'h6000 : 32'h7000, '0,
             {8{32'(k + 32'h600)}}, 1'b0);
    end
    i_read = 1'b0; d_read = 1'b0;
    step();
    #1;
    check("t6_idle", 256'({pmem_read, pmem_write}), 256'(0));
    check("excl", 256'(excl_err), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
